dct_input_pairer: RTL and testbench

//  Upstream stage of the 8-point DCT stage-1 butterfly bank. Collects a serial

---
 rtl/dct_pkg.sv | 19 +
 rtl/dct_input_pairer_if.sv | 28 ++
 rtl/dct_pair_bank.sv | 33 +++
 rtl/dct_input_pairer.sv | 119 +++++++++++
 tb/tb_dct_input_pairer.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dct_pkg.sv
// Shared constants and types for the DCT input stage.
package dct_pkg;

    localparam int unsigned DCT_N          = 8;
    localparam int unsigned DCT_HALF       = 4;
    localparam int unsigned DEFAULT_DATA_W = 32;

    // Index widths for the 8-entry write side and 4-pair read side.
    localparam int unsigned WR_IDX_W = $clog2(DCT_N);
    localparam int unsigned RD_IDX_W = $clog2(DCT_HALF);

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_state_e;

endpackage

// File: rtl/dct_input_pairer_if.sv
// Sample-in / pair-out handshake bundle of the DCT input pairer.
interface dct_input_pairer_if #(
    parameter int unsigned DATA_W = dct_pkg::DEFAULT_DATA_W
);

    logic [DATA_W-1:0]            in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic [DATA_W-1:0]            pair_x;
    logic [DATA_W-1:0]            pair_y;
    logic [dct_pkg::RD_IDX_W-1:0] pair_idx;
    logic                         pair_last;
    logic                         out_valid;
    logic                         out_ready;

    // Environment side: produces samples, consumes pairs.
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, pair_x, pair_y, pair_idx, pair_last, out_valid
    );

    // Pairer side.
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, pair_x, pair_y, pair_idx, pair_last, out_valid
    );

endinterface

// File: rtl/dct_pair_bank.sv
// 8-entry storage bank: serial writes, mirror-pair (x[i], x[7-i]) reads.
module dct_pair_bank
    import dct_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [WR_IDX_W-1:0] wr_idx,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [RD_IDX_W-1:0] rd_idx,
    output logic [DATA_W-1:0]   rd_x,
    output logic [DATA_W-1:0]   rd_y
);

    localparam logic [WR_IDX_W-1:0] LastIdx = WR_IDX_W'(DCT_N - 1);

    logic [DATA_W-1:0] mem_q [DCT_N];

    // Sample storage; contents are only read once the bank is FULL, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Mirror-pair read: entry i and entry 7-i.
    always_comb begin
        rd_x = mem_q[WR_IDX_W'(rd_idx)];
        rd_y = mem_q[LastIdx - WR_IDX_W'(rd_idx)];
    end

endmodule

// File: rtl/dct_input_pairer.sv
// Ping-pong collector of 8-sample blocks, re-emitted as 4 mirror pairs per block.
module dct_input_pairer
    import dct_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    output logic               busy,
    dct_input_pairer_if.slave  bus
);

    localparam logic [WR_IDX_W-1:0] LastWr   = WR_IDX_W'(DCT_N - 1);
    localparam logic [RD_IDX_W-1:0] LastPair = RD_IDX_W'(DCT_HALF - 1);

    bank_state_e         state_q [2];
    bank_state_e         state_d [2];
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [WR_IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [RD_IDX_W-1:0] rd_idx_q, rd_idx_d;

    logic                can_write;
    logic                can_read;
    logic                wr_fire;
    logic                rd_fire;
    logic [DATA_W-1:0]   bank_x [2];
    logic [DATA_W-1:0]   bank_y [2];

    // flush wins over both handshakes in the same cycle.
    assign wr_fire = bus.in_valid && can_write && !flush;
    assign rd_fire = bus.out_ready && can_read && !flush;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dct_pair_bank #(
            .DATA_W (DATA_W)
        ) u_bank (
            .clk     (clk),
            .wr_en   (wr_fire && (wr_bank_q == 1'(b))),
            .wr_idx  (wr_idx_q),
            .wr_data (bus.in_data),
            .rd_idx  (rd_idx_q),
            .rd_x    (bank_x[b]),
            .rd_y    (bank_y[b])
        );
    end

    // State register: bank states and read/write pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
        end
    end

    // Next state: write and read always hit different banks, so both may update.
    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        if (flush) begin
            state_d[0] = EMPTY;
            state_d[1] = EMPTY;
            wr_bank_d  = 1'b0;
            rd_bank_d  = 1'b0;
            wr_idx_d   = '0;
            rd_idx_d   = '0;
        end else begin
            if (wr_fire) begin
                if (wr_idx_q == LastWr) begin
                    state_d[wr_bank_q] = FULL;
                    wr_idx_d           = '0;
                    wr_bank_d          = !wr_bank_q;
                end else begin
                    state_d[wr_bank_q] = FILLING;
                    wr_idx_d           = wr_idx_q + WR_IDX_W'(1);
                end
            end
            if (rd_fire) begin
                if (rd_idx_q == LastPair) begin
                    state_d[rd_bank_q] = EMPTY;
                    rd_idx_d           = '0;
                    rd_bank_d          = !rd_bank_q;
                end else begin
                    state_d[rd_bank_q] = DRAINING;
                    rd_idx_d           = rd_idx_q + RD_IDX_W'(1);
                end
            end
        end
    end

    // Outputs: handshake flags from registered state, pair data muxed from the read bank.
    always_comb begin
        can_write     = (state_q[wr_bank_q] == EMPTY) || (state_q[wr_bank_q] == FILLING);
        can_read      = (state_q[rd_bank_q] == FULL) || (state_q[rd_bank_q] == DRAINING);
        bus.in_ready  = can_write;
        bus.out_valid = can_read;
        bus.pair_idx  = rd_idx_q;
        bus.pair_last = (rd_idx_q == LastPair);
        // Zeroed when idle so unwritten storage never shows on the outputs.
        bus.pair_x    = can_read ? bank_x[rd_bank_q] : '0;
        bus.pair_y    = can_read ? bank_y[rd_bank_q] : '0;
        busy          = (state_q[0] != EMPTY) || (state_q[1] != EMPTY);
    end

endmodule

// File: tb/tb_dct_input_pairer.sv
// Directed bench for dct_input_pairer.
module tb_dct_input_pairer;

    logic clk;
    logic rst_n;
    logic flush;
    logic busy;
    int   vectors;
    int   miscompares;

    dct_input_pairer_if #(.DATA_W(32)) bus ();

    dct_input_pairer #(
        .DATA_W (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++;
            $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++;
            $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
        vectors++; if (bus.pair_idx !== 2'd0) begin miscompares++;
            $display("FAIL reset pair_idx: got %0d want 0", bus.pair_idx); end
        vectors++; if (bus.pair_last !== 1'b0) begin miscompares++;
            $display("FAIL reset pair_last: got %b want 0", bus.pair_last); end
        vectors++; if (busy !== 1'b0) begin miscompares++;
            $display("FAIL reset busy: got %b want 0", busy); end
        vectors++; if (bus.pair_x !== 32'd0 || bus.pair_y !== 32'd0) begin miscompares++;
            $display("FAIL reset pair_xy: got %0d,%0d want 0,0", bus.pair_x, bus.pair_y); end
    endtask

    task automatic test_basic();
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(10 + k);
            vectors++; if (bus.in_ready !== 1'b1) begin miscompares++;
                $display("FAIL basic in_ready[%0d]: got %b want 1", k, bus.in_ready); end
            vectors++; if (bus.out_valid !== 1'b0) begin miscompares++;
                $display("FAIL basic early out_valid[%0d]: got %b want 0", k, bus.out_valid); end
            step();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (bus.out_valid !== 1'b1) begin miscompares++;
                $display("FAIL basic out_valid[%0d]: got %b want 1", i, bus.out_valid); end
            vectors++; if (bus.pair_x !== 32'(10 + i) || bus.pair_y !== 32'(17 - i)) begin
                miscompares++;
                $display("FAIL basic pair[%0d]: got %0d,%0d want %0d,%0d", i, bus.pair_x,
                         bus.pair_y, 10 + i, 17 - i); end
            vectors++; if (bus.pair_idx !== 2'(i) || bus.pair_last !== (i == 3)) begin
                miscompares++;
                $display("FAIL basic idx/last[%0d]: got %0d/%b want %0d/%b", i, bus.pair_idx,
                         bus.pair_last, i, (i == 3)); end
            step();
        end
        vectors++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++;
            $display("FAIL basic idle: got valid=%b busy=%b want 0,0", bus.out_valid, busy); end
    endtask

    task automatic test_stream();
        int p;
        int blk;
        int pi;
        do_reset();
        bus.out_ready = 1'b1;
        p = 0;
        for (int c = 0; c < 32; c++) begin
            if (c < 24) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 32'(100 + c);
                vectors++; if (bus.in_ready !== 1'b1) begin miscompares++;
                    $display("FAIL stream in_ready[%0d]: got %b want 1", c, bus.in_ready); end
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.out_valid === 1'b1) begin
                vectors++;
                if (p >= 12) begin
                    miscompares++;
                    $display("FAIL stream extra pair: got pair %0d want at most 12", p + 1);
                end else begin
                    blk = p / 4;
                    pi  = p % 4;
                    if (bus.pair_x !== 32'(100 + 8 * blk + pi) ||
                        bus.pair_y !== 32'(107 + 8 * blk - pi) || bus.pair_idx !== 2'(pi)) begin
                        miscompares++;
                        $display("FAIL stream pair[%0d]: got %0d,%0d idx %0d want %0d,%0d idx %0d",
                                 p, bus.pair_x, bus.pair_y, bus.pair_idx, 100 + 8 * blk + pi,
                                 107 + 8 * blk - pi, pi);
                    end
                end
                p++;
            end
            step();
        end
        vectors++; if (p != 12) begin miscompares++;
            $display("FAIL stream pair count: got %0d want 12", p); end
    endtask

    task automatic test_stall();
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(200 + k);
            vectors++; if (bus.in_ready !== 1'b1) begin miscompares++;
                $display("FAIL stall fill in_ready[%0d]: got %b want 1", k, bus.in_ready); end
            step();
        end
        bus.in_data = 32'd216;
        for (int s = 0; s < 3; s++) begin
            vectors++; if (bus.in_ready !== 1'b0) begin miscompares++;
                $display("FAIL stall in_ready[%0d]: got %b want 0", s, bus.in_ready); end
            vectors++; if (bus.out_valid !== 1'b1 || bus.pair_x !== 32'd200 ||
                           bus.pair_y !== 32'd207 || bus.pair_idx !== 2'd0) begin
                miscompares++;
                $display("FAIL stall hold[%0d]: got v=%b %0d,%0d idx %0d want v=1 200,207 idx 0",
                         s, bus.out_valid, bus.pair_x, bus.pair_y, bus.pair_idx); end
            step();
        end
        bus.out_ready = 1'b1;
        for (int d = 0; d < 4; d++) begin
            vectors++; if (bus.in_ready !== 1'b0) begin miscompares++;
                $display("FAIL stall drain in_ready[%0d]: got %b want 0", d, bus.in_ready); end
            vectors++; if (bus.pair_x !== 32'(200 + d) || bus.pair_y !== 32'(207 - d)) begin
                miscompares++;
                $display("FAIL stall drain pair[%0d]: got %0d,%0d want %0d,%0d", d, bus.pair_x,
                         bus.pair_y, 200 + d, 207 - d); end
            step();
        end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++;
            $display("FAIL stall freed in_ready: got %b want 1", bus.in_ready); end
        for (int d = 0; d < 4; d++) begin
            if (d == 1) bus.in_valid = 1'b0;
            vectors++; if (bus.pair_x !== 32'(208 + d) || bus.pair_y !== 32'(215 - d) ||
                           bus.pair_idx !== 2'(d)) begin
                miscompares++;
                $display("FAIL stall block2 pair[%0d]: got %0d,%0d idx %0d want %0d,%0d idx %0d",
                         d, bus.pair_x, bus.pair_y, bus.pair_idx, 208 + d, 215 - d, d); end
            step();
        end
        vectors++; if (bus.out_valid !== 1'b0 || busy !== 1'b1) begin miscompares++;
            $display("FAIL stall tail: got valid=%b busy=%b want 0,1", bus.out_valid, busy); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(40 + k);
            step();
        end
        // Drain bank 0 so its last pair leaves on the edge that writes bank 1's 8th sample.
        for (int j = 0; j < 8; j++) begin
            bus.in_data   = 32'(50 + j);
            bus.out_ready = (j >= 4);
            vectors++; if (bus.in_ready !== 1'b1) begin miscompares++;
                $display("FAIL simul in_ready[%0d]: got %b want 1", j, bus.in_ready); end
            if (j >= 4) begin
                vectors++; if (bus.pair_x !== 32'(36 + j) || bus.pair_y !== 32'(51 - j) ||
                               bus.pair_idx !== 2'(j - 4)) begin
                    miscompares++;
                    $display("FAIL simul A pair[%0d]: got %0d,%0d idx %0d want %0d,%0d idx %0d",
                             j - 4, bus.pair_x, bus.pair_y, bus.pair_idx, 36 + j, 51 - j, j - 4);
                end
            end
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (bus.out_valid !== 1'b1 || bus.pair_x !== 32'(50 + i) ||
                           bus.pair_y !== 32'(57 - i) || bus.pair_last !== (i == 3)) begin
                miscompares++;
                $display("FAIL simul B pair[%0d]: got v=%b %0d,%0d last %b want v=1 %0d,%0d last %b",
                         i, bus.out_valid, bus.pair_x, bus.pair_y, bus.pair_last, 50 + i, 57 - i,
                         (i == 3)); end
            step();
        end
        vectors++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++;
            $display("FAIL simul idle: got valid=%b busy=%b want 0,0", bus.out_valid, busy); end
    endtask

    task automatic test_flush();
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(30 + k);
            step();
        end
        // A sample offered in the flush cycle must be dropped.
        flush       = 1'b1;
        bus.in_data = 32'd99;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        vectors++; if (busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush partial: got busy=%b ready=%b valid=%b want 0,1,0", busy,
                     bus.in_ready, bus.out_valid); end
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(20 + k);
            vectors++; if (bus.out_valid !== 1'b0) begin miscompares++;
                $display("FAIL flush early out_valid[%0d]: got %b want 0", k, bus.out_valid); end
            step();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (bus.out_valid !== 1'b1 || bus.pair_x !== 32'(20 + i) ||
                           bus.pair_y !== 32'(27 - i)) begin
                miscompares++;
                $display("FAIL flush pair[%0d]: got v=%b %0d,%0d want v=1 %0d,%0d", i,
                         bus.out_valid, bus.pair_x, bus.pair_y, 20 + i, 27 - i); end
            step();
        end
        // Flush a complete, undrained block.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(80 + k);
            step();
        end
        bus.in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        vectors++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++;
            $display("FAIL flush full: got valid=%b busy=%b want 0,0", bus.out_valid, busy); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(60 + k);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        step();
        vectors++; if (bus.out_valid !== 1'b1 || bus.pair_idx !== 2'd2) begin miscompares++;
            $display("FAIL arst mid-drain: got v=%b idx %0d want v=1 idx 2", bus.out_valid,
                     bus.pair_idx); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL arst immediate: got valid=%b busy=%b ready=%b want 0,0,1",
                     bus.out_valid, busy, bus.in_ready); end
        vectors++; if (bus.pair_idx !== 2'd0 || bus.pair_x !== 32'd0) begin miscompares++;
            $display("FAIL arst outputs: got idx %0d x %0d want 0,0", bus.pair_idx, bus.pair_x); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++;
            $display("FAIL arst release out_valid: got %b want 0", bus.out_valid); end
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(70 + k);
            step();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (bus.out_valid !== 1'b1 || bus.pair_x !== 32'(70 + i) ||
                           bus.pair_y !== 32'(77 - i) || bus.pair_idx !== 2'(i)) begin
                miscompares++;
                $display("FAIL arst pair[%0d]: got v=%b %0d,%0d idx %0d want v=1 %0d,%0d idx %0d",
                         i, bus.out_valid, bus.pair_x, bus.pair_y, bus.pair_idx, 70 + i, 77 - i,
                         i); end
            step();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_stream();
        test_stall();
        test_simultaneous();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
